uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
REQ-002 CLOCK_FREQUENCY, 50_000_000, i_clk frequency in Hz.
REQ-003 BAUD_RATE, 115200, serial bit rate; BIT_CYCLES = CLOCK_FREQUENCY/BAUD_RATE (integer division).
REQ-004 NUM_REQ, 4, number of requesters (>=1).
REQ-005 HOLD_TIMEOUT, 1_000_000, cycles an owner may stall mid-packet before forced release.
REQ-006 Ports SHALL be, one per line: name direction width meaning.
REQ-007 i_clk input 1 sole clock, all logic on rising edge.
REQ-008 i_rst_n input 1 reset, asynchronous, active-low.
REQ-009 i_req_valid input NUM_REQ per-requester byte valid.
REQ-010 i_req_data input 8*NUM_REQ flattened bytes; requester k at bits [8k+7:8k].
REQ-011 i_req_last input NUM_REQ byte is final byte of its packet.
REQ-012 o_req_ready output NUM_REQ one-hot byte-accept strobe.
REQ-013 o_grant output NUM_REQ one-hot current owner, zero when none.
REQ-014 o_tx_byte output 8 byte to transmitter.
REQ-015 o_tx_begin output 1 transmitter start request.
REQ-016 o_busy output 1 high in every state except IDLE.
REQ-017 o_timeout output 1 one-cycle pulse on forced release.

Function
REQ-018 FSM states SHALL be IDLE, LOCKED, START, WAIT.
REQ-019 IDLE: if any i_req_valid bit is set, SHALL select owner round-robin, searching from (last_owner+1) mod NUM_REQ upward with wrap, register o_grant, enter LOCKED next cycle.
REQ-020 LOCKED: o_req_ready[owner] SHALL equal i_req_valid[owner] combinationally; other ready bits 0.
REQ-021 On a LOCKED transfer edge, byte and last flag SHALL be latched, o_tx_byte updated, state -> START.
REQ-022 START: o_tx_begin SHALL be high for exactly BIT_CYCLES cycles, then state -> WAIT.
REQ-023 WAIT: SHALL last exactly 10*BIT_CYCLES cycles; total begin-to-next-accept spacing >= 11 bit periods.
REQ-024 WAIT end: latched last=0 -> LOCKED (owner kept); last=1 -> IDLE, o_grant cleared, last_owner updated.
REQ-025 Latency: valid asserted in IDLE at edge k -> ready high during cycle k+1 -> o_tx_begin rises at edge k+2.
REQ-026 o_tx_byte SHALL remain stable from latch until next latch; i_req_data changes while ready low are ignored.
REQ-027 LOCKED with owner valid low for HOLD_TIMEOUT consecutive cycles SHALL pulse o_timeout, go IDLE, update last_owner.
REQ-028 Requests from non-owners SHALL never be accepted mid-packet; they wait for IDLE.
REQ-029 Back-to-back packets from one sole requester SHALL be re-granted with exactly one IDLE cycle between.
REQ-030 NUM_REQ=1 SHALL behave identically with a fixed owner.
REQ-031 Cycle counter SHALL be sized $clog2(10*BIT_CYCLES+1) bits, down-counting, reloaded per state; timeout counter sized $clog2(HOLD_TIMEOUT+1).

Reset
REQ-032 While i_rst_n=0: state IDLE, o_grant=0, o_req_ready=0, o_tx_byte=8'h00, o_tx_begin=0, o_busy=0, o_timeout=0, counters 0, last_owner=NUM_REQ-1 (requester 0 wins first).
REQ-033 Reset mid-frame SHALL drop o_tx_begin asynchronously; no pending byte is retained after release.

Structure
REQ-034 State encoding localparams and BIT_CYCLES/frame-length constants SHALL live in shared package uart_pkg.
REQ-035 Round-robin priority pick SHALL be sub-module rr_pick (inputs request vector, last_owner; output one-hot, valid).

Verification (CLOCK_FREQUENCY=1000, BAUD_RATE=100 -> BIT_CYCLES=10, HOLD_TIMEOUT=50, NUM_REQ=4)
REQ-036 Req0 sends 8'hA5 last=1 -> ready at cycle 1, begin high cycles 2..11, next IDLE at cycle 112, o_tx_byte=8'hA5 throughout.
REQ-037 Req0 3-byte packet 8'h01,02,03 while req2 valid -> req2 not granted until req0 last byte completes; begin rises every 111 cycles.
REQ-038 All four valid continuously, one-byte packets -> grant order 0,1,2,3,0.
REQ-039 Req1 sends non-last byte then drops valid -> o_timeout pulse exactly 50 cycles after LOCKED re-entry, o_grant=0 next cycle.
REQ-040 i_rst_n low at cycle 5 of START -> o_tx_begin=0 same cycle, all outputs at reset values; after release req0 granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter: FSM encoding,
// frame timing in bit periods, and the latched byte payload.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOCKED = 2'd1;
  localparam state_t ST_START  = 2'd2;
  localparam state_t ST_WAIT   = 2'd3;

  // Begin strobe spans one bit period, the remaining frame ten more.
  localparam int unsigned START_BIT_PERIODS = 1;
  localparam int unsigned WAIT_BIT_PERIODS  = 10;
  localparam int unsigned BYTE_W            = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } tx_payload_t;

  function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                             input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: searches upward from the requester after
// last_owner, wrapping, and returns the first active request.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last_owner,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid
);

  int unsigned idx;
  logic        found;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(i_last_owner) + i) % NUM_REQ;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && (k == idx) && i_req[k]) begin
          o_gnt[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter in front of a UART transmitter: one requester owns the
// link for a whole packet, with bytes paced at one UART frame each.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned HOLD_TIMEOUT    = 1_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_begin,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam int unsigned BIT_CYCLES   = bit_cycles(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned START_CYCLES = START_BIT_PERIODS * BIT_CYCLES;
  localparam int unsigned WAIT_CYCLES  = WAIT_BIT_PERIODS * BIT_CYCLES;
  localparam int unsigned CW           = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned TW           = $clog2(HOLD_TIMEOUT + 1);
  localparam int unsigned IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_owner_q, last_owner_d;
  tx_payload_t        pay_q, pay_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic               owner_valid;
  logic [7:0]         owner_data;
  logic               owner_last;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .i_req        (i_req_valid),
    .i_last_owner (last_owner_q),
    .o_gnt        (pick_gnt),
    .o_valid      (pick_valid)
  );

  // Encode the pick and select the current owner's request lane.
  always_comb begin
    pick_idx    = '0;
    owner_valid = 1'b0;
    owner_data  = '0;
    owner_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) pick_idx = IW'(k);
      if (owner_q == IW'(k)) begin
        owner_valid = i_req_valid[k];
        owner_data  = i_req_data[8*k +: 8];
        owner_last  = i_req_last[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_LOCKED;
      ST_LOCKED: begin
        if (owner_valid)       state_d = ST_START;
        else if (tmo_q == '0)  state_d = ST_IDLE;
      end
      ST_START:  if (cnt_q == '0) state_d = ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_d = pay_q.last ? ST_IDLE : ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, counters and ownership bookkeeping.
  always_comb begin
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    pay_d        = pay_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          tmo_d   = TW'(HOLD_TIMEOUT - 1);
        end
      end
      ST_LOCKED: begin
        if (owner_valid) begin
          pay_d.data = owner_data;
          pay_d.last = owner_last;
          cnt_d      = CW'(START_CYCLES - 1);
        end else if (tmo_q == '0) begin
          timeout_d    = 1'b1;
          grant_d      = '0;
          last_owner_d = owner_q;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_START: begin
        if (cnt_q == '0) cnt_d = CW'(WAIT_CYCLES - 1);
        else             cnt_d = cnt_q - CW'(1);
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pay_q.last) begin
          grant_d      = '0;
          last_owner_d = owner_q;
        end else begin
          tmo_d = TW'(HOLD_TIMEOUT - 1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      pay_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pay_q        <= pay_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_req_ready = (state_q == ST_LOCKED) ? (grant_q & i_req_valid) : '0;
  assign o_grant     = grant_q;
  assign o_tx_byte   = pay_q.data;
  assign o_tx_begin  = (state_q == ST_START);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at BIT_CYCLES=10, HOLD_TIMEOUT=50.
// Cycle c is the interval after rising edge c; edge 1 first samples stimulus.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   valid;
  logic [8*NR-1:0] data;
  logic [NR-1:0]   last;
  logic [NR-1:0]   ready;
  logic [NR-1:0]   grant;
  logic [7:0]      tx_byte;
  logic            tx_begin;
  logic            busy;
  logic            timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  uart_tx_arbiter #(
    .CLOCK_FREQUENCY (1000),
    .BAUD_RATE       (100),
    .NUM_REQ         (NR),
    .HOLD_TIMEOUT    (50)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .i_req_data  (data),
    .i_req_last  (last),
    .o_req_ready (ready),
    .o_grant     (grant),
    .o_tx_byte   (tx_byte),
    .o_tx_begin  (tx_begin),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int c);
    repeat (c - cur) @(negedge clk);
    cur = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur   = 0;
  endtask

  task automatic chk_reset_outs(input string p);
    check({p, "_ready"},   32'(ready),    32'h0);
    check({p, "_grant"},   32'(grant),    32'h0);
    check({p, "_byte"},    32'(tx_byte),  32'h00);
    check({p, "_begin"},   32'(tx_begin), 32'h0);
    check({p, "_busy"},    32'(busy),     32'h0);
    check({p, "_timeout"}, 32'(timeout),  32'h0);
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    data  = '0;
    #12;
    chk_reset_outs("rst");

    // Single one-byte packet from requester 0
    do_reset();
    valid[0] = 1'b1; data[7:0] = 8'hA5; last[0] = 1'b1;
    check("t1_c0_grant", 32'(grant), 32'h0);
    goto(1);
    check("t1_c1_ready", 32'(ready), 32'h1);
    check("t1_c1_grant", 32'(grant), 32'h1);
    check("t1_c1_begin", 32'(tx_begin), 32'h0);
    check("t1_c1_busy",  32'(busy), 32'h1);
    goto(2);
    check("t1_c2_begin", 32'(tx_begin), 32'h1);
    check("t1_c2_byte",  32'(tx_byte), 32'hA5);
    check("t1_c2_ready", 32'(ready), 32'h0);
    valid[0] = 1'b0; data[7:0] = 8'h3C;
    goto(11);
    check("t1_c11_begin", 32'(tx_begin), 32'h1);
    goto(12);
    check("t1_c12_begin", 32'(tx_begin), 32'h0);
    check("t1_c12_busy",  32'(busy), 32'h1);
    goto(60);
    check("t1_c60_byte",  32'(tx_byte), 32'hA5);
    goto(111);
    check("t1_c111_busy", 32'(busy), 32'h1);
    goto(112);
    check("t1_c112_busy",  32'(busy), 32'h0);
    check("t1_c112_grant", 32'(grant), 32'h0);
    check("t1_c112_byte",  32'(tx_byte), 32'hA5);

    // Three-byte packet from req0 while req2 waits
    do_reset();
    valid = 4'b0101;
    data[7:0] = 8'h01; data[23:16] = 8'h77;
    last = 4'b0100;
    goto(1);
    check("t2_c1_ready", 32'(ready), 32'h1);
    check("t2_c1_grant", 32'(grant), 32'h1);
    goto(2);
    check("t2_c2_byte", 32'(tx_byte), 32'h01);
    data[7:0] = 8'h02;
    goto(50);
    check("t2_c50_byte", 32'(tx_byte), 32'h01);
    goto(112);
    check("t2_c112_ready", 32'(ready), 32'h1);
    check("t2_c112_grant", 32'(grant), 32'h1);
    check("t2_c112_begin", 32'(tx_begin), 32'h0);
    goto(113);
    check("t2_c113_begin", 32'(tx_begin), 32'h1);
    check("t2_c113_byte",  32'(tx_byte), 32'h02);
    data[7:0] = 8'h03; last[0] = 1'b1;
    goto(223);
    check("t2_c223_begin", 32'(tx_begin), 32'h0);
    check("t2_c223_grant", 32'(grant), 32'h1);
    goto(224);
    check("t2_c224_begin", 32'(tx_begin), 32'h1);
    check("t2_c224_byte",  32'(tx_byte), 32'h03);
    valid[0] = 1'b0;
    goto(333);
    check("t2_c333_grant", 32'(grant), 32'h1);
    goto(334);
    check("t2_c334_grant", 32'(grant), 32'h0);
    check("t2_c334_busy",  32'(busy), 32'h0);
    goto(335);
    check("t2_c335_grant", 32'(grant), 32'h4);
    check("t2_c335_ready", 32'(ready), 32'h4);

    // All four requesters continuously valid with one-byte packets
    do_reset();
    valid = 4'b1111; last = 4'b1111;
    data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    goto(1);
    check("t3_g0", 32'(grant), 32'h1);
    goto(112);
    check("t3_gap", 32'(grant), 32'h0);
    goto(113);
    check("t3_g1", 32'(grant), 32'h2);
    goto(114);
    check("t3_b1", 32'(tx_byte), 32'hB1);
    goto(225);
    check("t3_g2", 32'(grant), 32'h4);
    goto(226);
    check("t3_b2", 32'(tx_byte), 32'hC2);
    goto(337);
    check("t3_g3", 32'(grant), 32'h8);
    goto(338);
    check("t3_b3", 32'(tx_byte), 32'hD3);
    goto(449);
    check("t3_g4", 32'(grant), 32'h1);
    goto(450);
    check("t3_b4", 32'(tx_byte), 32'hA0);

    // Req1 stalls mid-packet and is forcibly released
    do_reset();
    valid[1] = 1'b1; data[15:8] = 8'h5A; last[1] = 1'b0;
    goto(1);
    check("t4_c1_grant", 32'(grant), 32'h2);
    goto(2);
    valid[1] = 1'b0;
    goto(112);
    check("t4_c112_grant", 32'(grant), 32'h2);
    check("t4_c112_busy",  32'(busy), 32'h1);
    check("t4_c112_tmo",   32'(timeout), 32'h0);
    goto(161);
    check("t4_c161_tmo",   32'(timeout), 32'h0);
    check("t4_c161_grant", 32'(grant), 32'h2);
    goto(162);
    check("t4_c162_tmo",   32'(timeout), 32'h1);
    check("t4_c162_busy",  32'(busy), 32'h0);
    goto(163);
    check("t4_c163_tmo",   32'(timeout), 32'h0);
    check("t4_c163_grant", 32'(grant), 32'h0);

    // Reset asserted mid-START, then fresh arbitration
    do_reset();
    valid[0] = 1'b1; data[7:0] = 8'hC3; last[0] = 1'b1;
    goto(6);
    check("t5_c6_begin", 32'(tx_begin), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t5");
    valid = 4'b0111; last = 4'b0111;
    data = {8'h00, 8'h22, 8'h11, 8'h66};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur = 0;
    goto(1);
    check("t5_c1_grant", 32'(grant), 32'h1);
    goto(2);
    check("t5_c2_byte", 32'(tx_byte), 32'h66);

    // Sole requester re-granted after one IDLE cycle
    do_reset();
    valid[3] = 1'b1; data[31:24] = 8'h9E; last[3] = 1'b1;
    goto(1);
    check("t6_c1_grant", 32'(grant), 32'h8);
    goto(112);
    check("t6_c112_busy",  32'(busy), 32'h0);
    check("t6_c112_grant", 32'(grant), 32'h0);
    goto(113);
    check("t6_c113_grant", 32'(grant), 32'h8);
    check("t6_c113_begin", 32'(tx_begin), 32'h0);
    goto(114);
    check("t6_c114_begin", 32'(tx_begin), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
